// File: rtl/xbus_arbiter.sv
// XBus channel arbiter: pairs one pending writer with one pending reader
// on a different port, round-robin, and flags sustained request stalls.
module xbus_arbiter #(
  parameter int NPORT = 4,
  parameter int DW    = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                posedge_big_clk,
  input  logic [NPORT-1:0]    wr_req,
  input  logic [NPORT*DW-1:0] wr_data,
  input  logic [NPORT-1:0]    rd_req,
  output logic [NPORT-1:0]    wr_ack,
  output logic [NPORT-1:0]    rd_valid,
  output logic [DW-1:0]       rd_data,
  output logic                deadlock
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic {ARB, ACK} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW-1:0]   wsel, rsel;
  logic [PW-1:0]   w_idx, r_idx;
  logic            hit;
  logic [DW-1:0]   word;
  logic [1:0]      stall_cnt, stall_nxt;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(NPORT-1)) ? '0 : p + 1'b1;
  endfunction

  // Walk writers from wr_ptr; for each, walk readers from rd_ptr,
  // skipping the writer's own port. First pair found wins.
  always_comb begin
    int w;
    int r;
    hit   = 1'b0;
    w_idx = '0;
    r_idx = '0;
    w     = 0;
    r     = 0;
    for (int k = 0; k < NPORT; k++) begin
      w = (int'(wr_ptr) + k) % NPORT;
      if (!hit && wr_req[PW'(w)]) begin
        for (int j = 0; j < NPORT; j++) begin
          r = (int'(rd_ptr) + j) % NPORT;
          if (!hit && rd_req[PW'(r)] && r != w) begin
            hit   = 1'b1;
            w_idx = PW'(w);
            r_idx = PW'(r);
          end
        end
      end
    end
  end

  assign word = wr_data[w_idx*DW +: DW];

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB: if (hit) state_nxt = ACK;
      ACK: state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    stall_nxt = stall_cnt;
    if (state == ACK || (wr_req == '0 && rd_req == '0))
      stall_nxt = '0;
    else if (posedge_big_clk && stall_cnt != 2'd3)
      stall_nxt = stall_cnt + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wsel      <= '0;
      rsel      <= '0;
      rd_data   <= '0;
      stall_cnt <= '0;
      deadlock  <= 1'b0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_nxt;
      if (stall_nxt >= 2'd2)
        deadlock <= 1'b1;
      if (state == ARB && hit) begin
        wsel    <= w_idx;
        rsel    <= r_idx;
        rd_data <= word;
      end
      if (state == ACK) begin
        wr_ptr <= inc(wsel);
        rd_ptr <= inc(rsel);
      end
    end
  end

  assign wr_ack   = (state == ACK) ? (NPORT'(1) << wsel) : '0;
  assign rd_valid = (state == ACK) ? (NPORT'(1) << rsel) : '0;

endmodule

// File: tb/tb_xbus_arbiter.sv
// Scoreboard bench for xbus_arbiter (NPORT=4, DW=11).
// Inputs change on negedge; outputs sampled on negedge.
module tb_xbus_arbiter;

  typedef struct packed {
    logic [7:0]  cyc;
    logic [3:0]  wa;
    logic [3:0]  rv;
    logic [10:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        posedge_big_clk;
  logic [3:0]  wr_req;
  logic [43:0] wr_data;
  logic [3:0]  rd_req;
  logic [3:0]  wr_ack;
  logic [3:0]  rd_valid;
  logic [10:0] rd_data;
  logic        deadlock;

  exp_t q[$];
  exp_t e, got;
  int   checks = 0;
  int   errors = 0;

  xbus_arbiter #(.NPORT(4), .DW(11)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .posedge_big_clk (posedge_big_clk),
    .wr_req          (wr_req),
    .wr_data         (wr_data),
    .rd_req          (rd_req),
    .wr_ack          (wr_ack),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .deadlock        (deadlock)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0;
    posedge_big_clk = 1'b0;
    wr_req = 4'b0001;
    rd_req = 4'b0010;
    wr_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_ack, rd_valid, rd_data, deadlock} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0",
               {wr_ack, rd_valid, rd_data, deadlock});
    end
    wr_req = '0;
    rd_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    wr_data[0*11 +: 11] = 11'sd100;
    wr_req = 4'b0001;
    rd_req = 4'b0100;
    q.push_back('{8'd1, 4'b0001, 4'b0100, 11'd100});
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (|wr_ack || |rd_valid) begin
        checks++;
        got = '{8'(c), wr_ack, rd_valid, rd_data};
        if (q.size() == 0) begin
          errors++;
          $display("FAIL basic_extra got %h exp none", got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL basic_xfer got %h exp %h", got, e);
          end
        end
        wr_req &= ~wr_ack;
        rd_req &= ~rd_valid;
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL basic_missing got %0d left exp 0", q.size());
    end
    q.delete();
    checks++;
    if (rd_data !== 11'd100) begin
      errors++;
      $display("FAIL basic_hold got %h exp %h", rd_data, 11'd100);
    end
    // Negative word: -999 is 11'h419 in 11-bit two's complement.
    wr_data[3*11 +: 11] = -11'sd999;
    wr_req = 4'b1000;
    rd_req = 4'b0010;
    q.push_back('{8'd1, 4'b1000, 4'b0010, 11'h419});
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (|wr_ack || |rd_valid) begin
        checks++;
        got = '{8'(c), wr_ack, rd_valid, rd_data};
        if (q.size() == 0) begin
          errors++;
          $display("FAIL neg_extra got %h exp none", got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL neg_xfer got %h exp %h", got, e);
          end
        end
        wr_req &= ~wr_ack;
        rd_req &= ~rd_valid;
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL neg_missing got %0d left exp 0", q.size());
    end
    q.delete();
  endtask

  task automatic test_round_robin;
    rst_n = 1'b0;
    @(negedge clk);
    wr_data[0*11 +: 11] = 11'd5;
    wr_data[1*11 +: 11] = 11'd6;
    wr_data[2*11 +: 11] = 11'd7;
    wr_req = 4'b0111;
    rd_req = 4'b1000;
    rst_n = 1'b1;
    // One transfer every other cycle, beginning right after the first edge.
    q.push_back('{8'd1, 4'b0001, 4'b1000, 11'd5});
    q.push_back('{8'd3, 4'b0010, 4'b1000, 11'd6});
    q.push_back('{8'd5, 4'b0100, 4'b1000, 11'd7});
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (|wr_ack || |rd_valid) begin
        checks++;
        got = '{8'(c), wr_ack, rd_valid, rd_data};
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rr_extra got %h exp none", got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL rr_xfer got %h exp %h", got, e);
          end
        end
        wr_req &= ~wr_ack;
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rr_missing got %0d left exp 0", q.size());
    end
    q.delete();
    rd_req = '0;
    @(negedge clk);
  endtask

  task automatic test_self_exclusion;
    wr_data[1*11 +: 11] = 11'd321;
    wr_req = 4'b0010;
    rd_req = 4'b0010;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (|wr_ack || |rd_valid) begin
        checks++;
        errors++;
        $display("FAIL self_pulse got %b/%b exp 0000/0000",
                 wr_ack, rd_valid);
      end
    end
    rd_req = 4'b0011;
    q.push_back('{8'd1, 4'b0010, 4'b0001, 11'd321});
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (|wr_ack || |rd_valid) begin
        checks++;
        got = '{8'(c), wr_ack, rd_valid, rd_data};
        if (q.size() == 0) begin
          errors++;
          $display("FAIL self_extra got %h exp none", got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL self_xfer got %h exp %h", got, e);
          end
        end
        wr_req &= ~wr_ack;
        rd_req &= ~rd_valid;
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL self_missing got %0d left exp 0", q.size());
    end
    q.delete();
    rd_req = '0;
    @(negedge clk);
  endtask

  task automatic test_deadlock;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wr_req = 4'b0011;
    rd_req = 4'b0000;
    repeat (3) @(negedge clk);
    posedge_big_clk = 1'b1;
    @(negedge clk);
    posedge_big_clk = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (deadlock !== 1'b0) begin
      errors++;
      $display("FAIL dl_one_pulse got %b exp 0", deadlock);
    end
    posedge_big_clk = 1'b1;
    @(negedge clk);
    posedge_big_clk = 1'b0;
    checks++;
    if (deadlock !== 1'b1) begin
      errors++;
      $display("FAIL dl_two_pulse got %b exp 1", deadlock);
    end
    rd_req = 4'b0100;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      wr_req &= ~wr_ack;
      if (|rd_valid) rd_req = 4'b0100;
    end
    checks++;
    if (deadlock !== 1'b1 || wr_req !== 4'b0000) begin
      errors++;
      $display("FAIL dl_sticky got %b/%b exp 1/0000", deadlock, wr_req);
    end
    rd_req = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (deadlock !== 1'b0) begin
      errors++;
      $display("FAIL dl_reset got %b exp 0", deadlock);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_ack;
    wr_data[2*11 +: 11] = 11'd55;
    wr_req = 4'b0100;
    rd_req = 4'b0001;
    @(negedge clk);
    checks++;
    if (wr_ack !== 4'b0100 || rd_valid !== 4'b0001 || rd_data !== 11'd55) begin
      errors++;
      $display("FAIL mid_ack_pre got %b/%b/%h exp 0100/0001/037",
               wr_ack, rd_valid, rd_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_ack, rd_valid, rd_data, deadlock} !== 20'd0) begin
      errors++;
      $display("FAIL mid_ack_abort got %h exp 0",
               {wr_ack, rd_valid, rd_data, deadlock});
    end
    wr_req = '0;
    rd_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (|wr_ack || |rd_valid) begin
        checks++;
        errors++;
        $display("FAIL mid_ack_post got %b/%b exp 0000/0000",
                 wr_ack, rd_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_self_exclusion();
    test_deadlock();
    test_reset_mid_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
